// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - MIPS control-flow encodings shared by branch_ctrl and branch_decode
package mips_ctrl_pkg;

    localparam logic [5:0] SPECIAL = 6'h00;
    localparam logic [5:0] REGIMM  = 6'h01;
    localparam logic [5:0] J       = 6'h02;
    localparam logic [5:0] JAL     = 6'h03;
    localparam logic [5:0] BEQ     = 6'h04;
    localparam logic [5:0] BNE     = 6'h05;
    localparam logic [5:0] BLEZ    = 6'h06;
    localparam logic [5:0] BGTZ    = 6'h07;

    localparam logic [5:0] JR      = 6'h08;
    localparam logic [5:0] JALR    = 6'h09;

    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    localparam logic [4:0] LINK_REG_RA = 5'd31;

    typedef enum logic [1:0] {
        BK_NONE = 2'd0,
        BK_BR   = 2'd1,
        BK_J    = 2'd2,
        BK_JR   = 2'd3
    } branch_kind_t;

endpackage

// File: rtl/branch_decode.sv
// rtl/branch_decode.sv - combinational classification of control instructions and their condition
module branch_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0]  instruction_word,
    input  logic         N,
    input  logic         Z,
    output branch_kind_t kind,
    output logic         taken,
    output logic         is_link,
    output logic [4:0]   link_reg
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;

    assign opcode = instruction_word[31:26];
    assign rt     = instruction_word[20:16];
    assign rd     = instruction_word[15:11];
    assign funct  = instruction_word[5:0];

    always_comb begin
        kind     = BK_NONE;
        taken    = 1'b0;
        is_link  = 1'b0;
        link_reg = 5'd0;
        case (opcode)
            SPECIAL: begin
                if (funct == JR) begin
                    kind  = BK_JR;
                    taken = 1'b1;
                end else if (funct == JALR) begin
                    kind     = BK_JR;
                    taken    = 1'b1;
                    is_link  = 1'b1;
                    link_reg = rd;
                end
            end
            REGIMM: begin
                case (rt)
                    RT_BLTZ: begin
                        kind  = BK_BR;
                        taken = N;
                    end
                    RT_BGEZ: begin
                        kind  = BK_BR;
                        taken = !N;
                    end
                    RT_BLTZAL: begin
                        kind     = BK_BR;
                        taken    = N;
                        is_link  = 1'b1;
                        link_reg = LINK_REG_RA;
                    end
                    RT_BGEZAL: begin
                        kind     = BK_BR;
                        taken    = !N;
                        is_link  = 1'b1;
                        link_reg = LINK_REG_RA;
                    end
                    default: ;
                endcase
            end
            J: begin
                kind  = BK_J;
                taken = 1'b1;
            end
            JAL: begin
                kind     = BK_J;
                taken    = 1'b1;
                is_link  = 1'b1;
                link_reg = LINK_REG_RA;
            end
            BEQ: begin
                kind  = BK_BR;
                taken = Z;
            end
            BNE: begin
                kind  = BK_BR;
                taken = !Z;
            end
            BLEZ: begin
                kind  = BK_BR;
                taken = N | Z;
            end
            BGTZ: begin
                kind  = BK_BR;
                taken = !N & !Z;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolution with one delay slot, link writes and sticky finish
module branch_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] FINISH_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        state,
    input  logic [31:0] instruction_word,
    input  logic [31:0] pc_in,
    input  logic        N,
    input  logic        Z,
    input  logic [31:0] read_data_0,
    output logic        redirect_valid,
    output logic [31:0] redirect_target,
    output logic        link_en,
    output logic [4:0]  link_reg,
    output logic [31:0] link_addr,
    output logic        in_delay_slot,
    output logic        finish
);

    branch_kind_t kind;
    logic         taken;
    logic         is_link;
    logic [4:0]   dec_link_reg;

    logic         pending_valid;
    logic [31:0]  pending_target;
    logic         finish_pending;

    logic         active;
    logic [31:0]  pc_plus4;
    logic [31:0]  br_offset;
    logic [31:0]  target;

    branch_decode u_decode (
        .instruction_word (instruction_word),
        .N                (N),
        .Z                (Z),
        .kind             (kind),
        .taken            (taken),
        .is_link          (is_link),
        .link_reg         (dec_link_reg)
    );

    // Only a fresh exec cycle outside a delay slot and before finish may act on control flow.
    assign active    = state && !in_delay_slot && !finish;
    assign pc_plus4  = pc_in + 32'd4;
    assign br_offset = {{14{instruction_word[15]}}, instruction_word[15:0], 2'b00};

    always_comb begin
        target = 32'd0;
        case (kind)
            BK_BR:   target = pc_plus4 + br_offset;
            BK_J:    target = {pc_plus4[31:28], instruction_word[25:0], 2'b00};
            BK_JR:   target = read_data_0;
            default: target = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_valid  <= 1'b0;
            pending_target <= 32'd0;
            finish_pending <= 1'b0;
            in_delay_slot  <= 1'b0;
            finish         <= 1'b0;
        end else if (state) begin
            if (in_delay_slot) begin
                pending_valid  <= 1'b0;
                in_delay_slot  <= 1'b0;
                finish_pending <= 1'b0;
                if (finish_pending) begin
                    finish <= 1'b1;
                end
            end else if (active && kind != BK_NONE) begin
                // The delay slot always executes, so it is flagged even for a not-taken branch.
                in_delay_slot  <= 1'b1;
                pending_valid  <= taken;
                finish_pending <= (kind == BK_JR) && (read_data_0 == FINISH_ADDR);
                if (taken) begin
                    pending_target <= target;
                end
            end
        end
    end

    assign redirect_valid  = pending_valid && state && !finish;
    assign redirect_target = redirect_valid ? pending_target : 32'd0;

    assign link_en   = active && is_link;
    assign link_reg  = link_en ? dec_link_reg : 5'd0;
    assign link_addr = link_en ? (pc_in + 32'd8) : 32'd0;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - scoreboard bench for branch_ctrl with directed instruction sequences
module tb_branch_ctrl;

    typedef struct {
        logic        rv;
        logic [31:0] tgt;
        logic        le;
        logic [4:0]  lr;
        logic [31:0] la;
        logic        ids;
        logic        fin;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        state;
    logic [31:0] instruction_word;
    logic [31:0] pc_in;
    logic        N;
    logic        Z;
    logic [31:0] read_data_0;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        link_en;
    logic [4:0]  link_reg;
    logic [31:0] link_addr;
    logic        in_delay_slot;
    logic        finish;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fails;
    int   cyc_no;
    bit   stim_done;

    localparam logic [31:0] NOP = 32'h0000_0000;

    branch_ctrl #(.FINISH_ADDR(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .state            (state),
        .instruction_word (instruction_word),
        .pc_in            (pc_in),
        .N                (N),
        .Z                (Z),
        .read_data_0      (read_data_0),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .link_en          (link_en),
        .link_reg         (link_reg),
        .link_addr        (link_addr),
        .in_delay_slot    (in_delay_slot),
        .finish           (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic rv, logic [31:0] tgt, logic le, logic [4:0] lr,
                                logic [31:0] la, logic ids, logic fin);
        exp_t e;
        e.rv = rv; e.tgt = tgt; e.le = le; e.lr = lr; e.la = la; e.ids = ids; e.fin = fin;
        return e;
    endfunction

    function automatic exp_t z0();
        return mk(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL cycle %0d %s: got 0x%08h expected 0x%08h", cyc_no, name, act, req);
        end
    endtask

    // One clock of stimulus; the expected outputs for that clock go to the scoreboard.
    task automatic cyc(input logic rst, input logic st, input logic [31:0] ins,
                       input logic [31:0] pc, input logic n, input logic z,
                       input logic [31:0] rd0, input bit chk, input exp_t e);
        @(posedge clk);
        #1;
        reset            = rst;
        state            = st;
        instruction_word = ins;
        pc_in            = pc;
        N                = n;
        Z                = z;
        read_data_0      = rd0;
        if (chk) exp_q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the oldest expectation.
    initial begin
        cyc_no = 0;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("redirect_valid",  {31'd0, redirect_valid}, {31'd0, e.rv});
                check("redirect_target", redirect_target,         e.tgt);
                check("link_en",         {31'd0, link_en},        {31'd0, e.le});
                check("link_reg",        {27'd0, link_reg},       {27'd0, e.lr});
                check("link_addr",       link_addr,               e.la);
                check("in_delay_slot",   {31'd0, in_delay_slot},  {31'd0, e.ids});
                check("finish",          {31'd0, finish},         {31'd0, e.fin});
            end
        end
    end

    initial begin
        stim_done = 1'b0;
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1; state = 1'b0; instruction_word = NOP; pc_in = 32'd0;
        N = 1'b0; Z = 1'b0; read_data_0 = 32'd0;

        cyc(1, 0, NOP, 32'h0, 0, 0, 0, 0, z0());
        cyc(1, 0, NOP, 32'h0, 0, 0, 0, 0, z0());
        cyc(0, 0, NOP, 32'h0, 0, 0, 0, 1, z0());

        // BLTZ +2 at 0x10, taken
        cyc(0, 1, 32'h0480_0002, 32'h10, 1, 0, 0, 1, z0());
        cyc(0, 0, NOP, 32'h14, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h14, 0, 0, 0, 1, mk(1, 32'h1C, 0, 0, 0, 1, 0));
        cyc(0, 0, NOP, 32'h1C, 0, 0, 0, 1, z0());
        cyc(0, 1, NOP, 32'h1C, 0, 0, 0, 1, z0());

        // BEQ at 0x20, not taken: slot flagged, no redirect
        cyc(0, 0, NOP, 32'h20, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h1000_0003, 32'h20, 0, 0, 0, 1, z0());
        cyc(0, 0, NOP, 32'h24, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h24, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 0, NOP, 32'h28, 0, 0, 0, 1, z0());
        cyc(0, 1, NOP, 32'h28, 0, 0, 0, 1, z0());

        // JAL index 0x40 at 0x0040_0000
        cyc(0, 0, NOP, 32'h0040_0000, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h0C00_0040, 32'h0040_0000, 0, 0, 0, 1,
            mk(0, 0, 1, 5'd31, 32'h0040_0008, 0, 0));
        cyc(0, 0, NOP, 32'h0040_0004, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h0040_0004, 0, 0, 0, 1, mk(1, 32'h100, 0, 0, 0, 1, 0));

        // JALR rd=7 rs=0x1234 at 0x100
        cyc(0, 0, NOP, 32'h100, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h00A0_3809, 32'h100, 0, 0, 32'h1234, 1,
            mk(0, 0, 1, 5'd7, 32'h108, 0, 0));
        cyc(0, 0, NOP, 32'h104, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h104, 0, 0, 0, 1, mk(1, 32'h1234, 0, 0, 0, 1, 0));

        // BGEZAL with N=1: not taken but still links
        cyc(0, 0, NOP, 32'h200, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h0491_0005, 32'h200, 1, 0, 0, 1, mk(0, 0, 1, 5'd31, 32'h208, 0, 0));
        cyc(0, 0, NOP, 32'h204, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h204, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));

        // BLEZ -4 at 0x0 with Z=1: target wraps below zero
        cyc(0, 0, NOP, 32'h0, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h1880_FFFC, 32'h0, 0, 1, 0, 1, z0());
        cyc(0, 0, NOP, 32'h4, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, NOP, 32'h4, 0, 0, 0, 1, mk(1, 32'hFFFF_FFF4, 0, 0, 0, 1, 0));

        // BNE taken at 0x300 with JAL in its delay slot
        cyc(0, 0, NOP, 32'h300, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h1485_0004, 32'h300, 0, 0, 0, 1, z0());
        cyc(0, 0, 32'h0C00_0040, 32'h304, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, 32'h0C00_0040, 32'h304, 0, 0, 0, 1, mk(1, 32'h314, 0, 0, 0, 1, 0));
        cyc(0, 0, NOP, 32'h314, 0, 0, 0, 1, z0());
        cyc(0, 1, NOP, 32'h314, 0, 0, 0, 1, z0());

        // BGTZ taken at 0x400, reset during the delay-slot fetch
        cyc(0, 0, NOP, 32'h400, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h1C80_0001, 32'h400, 0, 0, 0, 1, z0());
        cyc(1, 0, NOP, 32'h404, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 0, NOP, 32'h0, 0, 0, 0, 1, z0());
        cyc(0, 1, NOP, 32'h0, 0, 0, 0, 1, z0());
        cyc(0, 0, NOP, 32'h4, 0, 0, 0, 1, z0());
        cyc(0, 1, NOP, 32'h4, 0, 0, 0, 1, z0());

        // JR to FINISH_ADDR with ADDU in the slot, then J after finish
        cyc(0, 0, NOP, 32'h500, 0, 0, 0, 1, z0());
        cyc(0, 1, 32'h00A0_0008, 32'h500, 0, 0, 32'h0, 1, z0());
        cyc(0, 0, 32'h0085_1021, 32'h504, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 1, 0));
        cyc(0, 1, 32'h0085_1021, 32'h504, 0, 0, 0, 1, mk(1, 32'h0, 0, 0, 0, 1, 0));
        cyc(0, 0, 32'h0800_0010, 32'h508, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        cyc(0, 1, 32'h0800_0010, 32'h508, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        cyc(0, 0, 32'h0C00_0040, 32'h50C, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        cyc(0, 1, 32'h0C00_0040, 32'h50C, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        cyc(1, 0, NOP, 32'h0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));
        cyc(0, 0, NOP, 32'h0, 0, 0, 0, 1, z0());

        @(posedge clk);
        @(posedge clk);
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(posedge clk);
            budget++;
        end
        @(negedge clk);
        if (!stim_done) begin
            n_checks++;
            n_fails++;
            $display("FAIL timeout: stimulus still running after %0d cycles, expected done", budget);
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
